// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipelined MIPS core.
//   Stores from the memory stage are posted into a small circular write
//   buffer, and the buffer drains one entry per edge into a word RAM that
//   has a single write port. Loads are combinational. A load sees the RAM
//   word with every valid buffered store to the same word applied on top,
//   oldest to youngest. The program loader shares the RAM write port and
//   takes priority over drains.
// Ports:
//   clk, reset            clock, async active-high reset
//   memwriteM, sbM        store strobe, byte(1)/word(0) select
//   aluoutM, writedataM   byte address, store data
//   readdataM             load data (combinational from aluoutM)
//   load_en/addr/data     loader full-word write port
//   wbcount, wbfull       buffer occupancy, full flag (registered)
//   wboverflow            sticky: a store was dropped

module dmem_responder_lane #(
  parameter int WB_DEPTH = 4
) (
  input  logic [7:0]                ramByte,
  input  logic [WB_DEPTH-1:0]       sel,      // index 0 = oldest entry
  input  logic [WB_DEPTH-1:0][7:0]  entByte,
  output logic [7:0]                rdByte
);
  // Later (younger) hits overwrite earlier ones, so the youngest store wins.
  always_comb begin
    rdByte = ramByte;
    for (int i = 0; i < WB_DEPTH; i++)
      if (sel[i]) rdByte = entByte[i];
  end
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WB_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwriteM,
  input  logic                      sbM,
  input  logic [31:0]               aluoutM,
  input  logic [31:0]               writedataM,
  output logic [31:0]               readdataM,
  input  logic                      load_en,
  input  logic [31:0]               load_addr,
  input  logic [31:0]               load_data,
  output logic [$clog2(WB_DEPTH):0] wbcount,
  output logic                      wbfull,
  output logic                      wboverflow
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int PW        = $clog2(WB_DEPTH);
  localparam int CW        = PW + 1;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [AW-1:0]        idx;
    logic [31:0]          data;
    logic [NUM_LANES-1:0] mask;
  } wbEntry_t;

  wbEntry_t      wbMem [WB_DEPTH];
  logic [31:0]   ram   [DEPTH_WORDS];
  logic [PW-1:0] headPtr, tailPtr;

  wbEntry_t      newEnt, headEnt;
  logic          drain, enq;
  logic [CW-1:0] countNext;

  logic unusedAddrBits;
  assign unusedAddrBits = ^{aluoutM[31:AW+2], load_addr[31:AW+2], load_addr[1:0]};

  // New entry: sb replicates the byte into every lane and masks one lane.
  always_comb begin
    newEnt     = '0;
    newEnt.idx = aluoutM[AW+1:2];
    if (sbM) begin
      newEnt.data = {NUM_LANES{writedataM[7:0]}};
      newEnt.mask = NUM_LANES'(1) << aluoutM[1:0];
    end else begin
      newEnt.data = writedataM;
      newEnt.mask = '1;
    end
  end

  assign headEnt = wbMem[headPtr];
  // Loader owns the write port; a drain frees a slot for a same-edge store.
  assign drain     = !reset && !load_en && (wbcount != '0);
  assign enq       = memwriteM && (!wbfull || drain);
  assign countNext = wbcount + CW'(enq) - CW'(drain);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      wbcount    <= '0;
      wbfull     <= 1'b0;
      wboverflow <= 1'b0;
    end else begin
      if (drain) headPtr <= headPtr + 1'b1;
      if (enq)   tailPtr <= tailPtr + 1'b1;
      wbcount <= countNext;
      wbfull  <= (countNext == CW'(WB_DEPTH));
      if (memwriteM && !enq) wboverflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: validity comes from head/count.
  always_ff @(posedge clk)
    if (enq) wbMem[tailPtr] <= newEnt;

  // Single RAM write port; the loader works regardless of reset.
  always_ff @(posedge clk) begin
    if (load_en)
      ram[load_addr[AW+1:2]] <= load_data;
    else if (drain)
      for (int b = 0; b < NUM_LANES; b++)
        if (headEnt.mask[b]) ram[headEnt.idx][8*b +: 8] <= headEnt.data[8*b +: 8];
  end

  // Read path: RAM word, then buffer entries ordered oldest-first.
  logic [AW-1:0]                          rdIdx;
  logic [31:0]                            ramWord;
  logic [NUM_LANES-1:0][WB_DEPTH-1:0]     laneSel;
  logic [NUM_LANES-1:0][WB_DEPTH-1:0][7:0] laneByte;

  assign rdIdx   = aluoutM[AW+1:2];
  assign ramWord = ram[rdIdx];

  always_comb begin
    wbEntry_t ent;
    logic     hit;
    laneSel  = '0;
    laneByte = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      ent = wbMem[headPtr + PW'(i)];
      hit = (CW'(i) < wbcount) && (ent.idx == rdIdx);
      for (int l = 0; l < NUM_LANES; l++) begin
        laneSel[l][i]  = hit && ent.mask[l];
        laneByte[l][i] = ent.data[8*l +: 8];
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    dmem_responder_lane #(.WB_DEPTH(WB_DEPTH)) uLane (
      .ramByte (ramWord[8*l +: 8]),
      .sel     (laneSel[l]),
      .entByte (laneByte[l]),
      .rdByte  (readdataM[8*l +: 8])
    );
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int WBD   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwriteM = 1'b0, sbM = 1'b0;
  logic [31:0] aluoutM = '0, writedataM = '0, readdataM;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0;
  logic [$clog2(WBD):0] wbcount;
  logic        wbfull, wboverflow;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WB_DEPTH(WBD)) dut (
    .clk(clk), .reset(reset), .memwriteM(memwriteM), .sbM(sbM),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .wbcount(wbcount), .wbfull(wbfull), .wboverflow(wboverflow));

  always #5 clk = ~clk;

  int nChecks = 0, nFail = 0;
  bit chk = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: byte-lane memory plus an ordered list of pending stores.
  typedef struct { int idx; logic [31:0] data; logic [3:0] mask; } ent_t;
  logic [31:0] mRam [DEPTH];
  ent_t        q[$];
  bit          mOvf = 0;

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    logic [31:0] w;
    w = mRam[widx(a)];
    foreach (q[i])
      if (q[i].idx == widx(a))
        for (int b = 0; b < 4; b++)
          if (q[i].mask[b]) w[8*b +: 8] = q[i].data[8*b +: 8];
    return w;
  endfunction

  always @(posedge reset) begin
    q.delete();
    mOvf = 0;
  end

  always @(posedge clk) begin
    ent_t e;
    bit   dr;
    if (load_en) mRam[widx(load_addr)] = load_data;
    if (!reset) begin
      dr = !load_en && q.size() > 0;
      if (dr) begin
        e = q.pop_front();
        for (int b = 0; b < 4; b++)
          if (e.mask[b]) mRam[e.idx][8*b +: 8] = e.data[8*b +: 8];
      end
      if (memwriteM) begin
        if (q.size() < WBD) begin
          e.idx  = widx(aluoutM);
          e.mask = sbM ? (4'b1 << aluoutM[1:0]) : 4'hF;
          e.data = sbM ? {4{writedataM[7:0]}} : writedataM;
          q.push_back(e);
        end else mOvf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("m_read",  readdataM, mRead(aluoutM));
      check("m_count", 32'(wbcount), 32'(q.size()));
      check("m_full",  32'(wbfull), 32'(q.size() == WBD));
      check("m_ovf",   32'(wboverflow), 32'(mOvf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input bit sb, input logic [31:0] a, input logic [31:0] d);
    memwriteM = 1'b1; sbM = sb; aluoutM = a; writedataM = d;
    step();
    memwriteM = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    aluoutM = a;
    #1;
    check(nm, readdataM, exp);
  endtask

  initial begin
    // Preload every word during reset so all reads are defined.
    load_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      load_addr = 32'(i * 4); load_data = 32'h5A000000 | 32'(i);
      step();
    end
    load_addr = 32'h10; load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    check("rst_count", 32'(wbcount), 32'd0);
    reset = 1'b0;
    step();
    chk = 1;
    rd("loader_read", 32'h10, 32'hDEADBEEF);
    check("rst_full", 32'(wbfull), 32'd0);
    check("rst_ovf", 32'(wboverflow), 32'd0);

    // Byte store forwarding with the port held by the loader.
    load_en = 1'b1; load_addr = 32'h100; load_data = 32'hCAFEF00D;
    store(1, 32'h11, 32'h000000AA);
    rd("sb_fwd", 32'h10, 32'hDEADAAEF);
    check("sb_count", 32'(wbcount), 32'd1);
    load_en = 1'b0;
    step();
    check("sb_drained", 32'(wbcount), 32'd0);
    rd("sb_ram", 32'h10, 32'hDEADAAEF);

    // Ordering.
    load_en = 1'b1;
    store(0, 32'h20, 32'h11111111);
    store(1, 32'h23, 32'h00000022);
    rd("ord_2", 32'h20, 32'h22111111);
    store(0, 32'h20, 32'h33333333);
    store(1, 32'h20, 32'h00000044);
    rd("ord_4", 32'h20, 32'h33333344);
    check("ord_count", 32'(wbcount), 32'd4);
    check("ord_full", 32'(wbfull), 32'd1);
    load_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("ord_cnt3", 32'(wbcount), 32'd1);
    step();
    check("ord_cnt4", 32'(wbcount), 32'd0);
    rd("ord_ram", 32'h20, 32'h33333344);

    // Full with simultaneous drain.
    load_en = 1'b1;
    for (int k = 0; k < 4; k++) store(0, 32'h30 + 32'(4*k), 32'h30303030 + 32'(k));
    check("fd_full", 32'(wbfull), 32'd1);
    load_en = 1'b0;
    store(0, 32'h60, 32'h66666666);
    check("fd_count", 32'(wbcount), 32'd4);
    check("fd_ovf", 32'(wboverflow), 32'd0);
    rd("fd_ram", 32'h30, 32'h30303030);
    rd("fd_fwd", 32'h60, 32'h66666666);
    for (int i = 0; i < 4; i++) step();
    check("fd_empty", 32'(wbcount), 32'd0);

    // Overflow.
    load_en = 1'b1;
    for (int k = 0; k < 4; k++) store(0, 32'h40 + 32'(4*k), 32'h40000000 + 32'(k));
    check("ov_pre", 32'(wboverflow), 32'd0);
    store(0, 32'h50, 32'h40000004);
    check("ov_set", 32'(wboverflow), 32'd1);
    check("ov_count", 32'(wbcount), 32'd4);
    rd("ov_dropped", 32'h50, 32'h5A000014);
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("ov_sticky", 32'(wboverflow), 32'd1);
    check("ov_empty", 32'(wbcount), 32'd0);
    rd("ov_ram", 32'h4C, 32'h40000003);

    // Reset mid-operation.
    load_en = 1'b1;
    for (int k = 0; k < 3; k++) store(0, 32'h80 + 32'(4*k), 32'h80000000 + 32'(k));
    check("mr_count", 32'(wbcount), 32'd3);
    rd("mr_fwd", 32'h84, 32'h80000001);
    load_en = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mr_cnt0", 32'(wbcount), 32'd0);
    check("mr_ovf0", 32'(wboverflow), 32'd0);
    rd("mr_ram", 32'h84, 32'h5A000021);
    step(); step();
    check("mr_cnt_after", 32'(wbcount), 32'd0);
    rd("mr_ram_after", 32'h84, 32'h5A000021);
    rd("mr_keep", 32'h20, 32'h33333344);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. It serves the core's memory-stage port: `memwriteM`, `aluoutM`, `writedataM` and `sbM` come in, and `readdataM` goes back out. Stores are posted into a small write buffer that drains into a single-write-port word RAM. Loads are answered combinationally, with store-to-load forwarding from the buffer. A program-loader port shares the RAM write port and takes priority over buffer drains.

## Interface
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words; a power of two.
- `WB_DEPTH`, default 4: number of write-buffer entries; a power of two, at least 2.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `memwriteM`  in  1: store request this cycle.
- `sbM`  in  1: 1 = byte store (sb), 0 = word store (sw).
- `aluoutM`  in  32: byte address for loads and stores.
- `writedataM`  in  32: store data.
- `readdataM`  out  32: load data, combinational from `aluoutM`.
- `load_en`  in  1: loader write strobe.
- `load_addr`  in  32: loader byte address; bits [1:0] are ignored.
- `load_data`  in  32: loader word data.
- `wbcount`  out  $clog2(WB_DEPTH)+1: current buffer occupancy.
- `wbfull`  out  1: asserted when `wbcount == WB_DEPTH`.
- `wboverflow`  out  1: sticky; a store was dropped.

## Operation
- **Word index:** `aluoutM[$clog2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap.
- **Store entry:** each store enqueues `{index, data, mask[3:0]}`.
  - sw: mask 1111, data = `writedataM`, address bits [1:0] ignored.
  - sb: lane `L = aluoutM[1:0]`, little-endian (lane 0 = bits [7:0]). Mask is one-hot at L; data = `writedataM[7:0]` replicated into all four lanes.
- **Buffer:** circular FIFO with head pointer, tail pointer and count. Pointers wrap modulo `WB_DEPTH`.
- **Write-port arbitration, per edge:**
  - If `load_en`=1: RAM[`load_addr` index] gets `load_data` (full word). There is no drain this edge.
  - Else if count>0: the head entry is written to RAM under its mask, and head advances.
- **Enqueue:** happens on an edge with `memwriteM`=1 when either count<`WB_DEPTH` before the edge, or a drain occurs on that same edge.
- **Overflow:** if a store cannot be enqueued, it is dropped and `wboverflow` is set to 1. `wboverflow` is cleared only by reset.
- **Count update:** count' = count + enq − drain.
- **Load data:** take the RAM word at the index, then apply every valid buffer entry with a matching index in order from head (oldest) to tail (youngest), byte lane by byte lane under each mask. The youngest write to a lane wins.
- **Not forwarded:**
  - A store being enqueued in the same cycle; the core never issues a load and a store in M in the same cycle.
  - A loader write in the same cycle; the read returns the pre-edge RAM value.
- **Loader vs. buffered stores:** the loader does not flush or invalidate buffer entries. Older buffered stores drain over the loader data afterwards. Software loads the program only while the core is held in reset.
- **Reset:**
  - Buffer empty, both pointers 0, `wbcount`=0, `wbfull`=0, `wboverflow`=0.
  - RAM contents are not cleared.
  - `readdataM` reflects the RAM only, since no entries are valid.
  - `reset` asserted mid-drain discards all pending entries; no partial RAM write occurs after the reset edge.
- `load_en` remains functional during reset; the RAM write is independent of `reset`.

## Timing
- Store to buffer: 1 edge.
- Store to RAM: at least 2 edges. It lands on the first edge after enqueue where `load_en`=0 and the entry is at the head.
- Loads have zero-cycle latency (combinational). They see a store from the cycle after its enqueue edge, whether the data is in the buffer or already in RAM.
- `wbcount`, `wbfull` and `wboverflow` are registered state outputs and change only on an edge or on reset.
- With `load_en` held low, the buffer drains one entry per cycle, so sustained occupancy stays at or below 1. Occupancy grows only while the loader holds the port.
- **Full with simultaneous store and drain:** accepted; count stays at `WB_DEPTH`.
- **Full with store and `load_en`=1:** dropped; `wboverflow` rises on that edge.

## Test plan
- **Reset and loader:** assert reset, then `load_en` with `load_addr`=0x10, `load_data`=0xDEADBEEF, and release. Expect `aluoutM`=0x10 to give `readdataM`=0xDEADBEEF, with `wbcount`=0 and `wboverflow`=0.
- **Byte store forwarding:** with `load_en` high so nothing drains, issue sb `aluoutM`=0x11, `writedataM`=0x000000AA. Next cycle, a read of 0x10 returns 0xDEADAAEF and `wbcount`=1.
- **Ordering:** with `load_en` held on an unrelated address, issue sw 0x20 ← 0x11111111, then sb 0x23 ← 0x22, then sw 0x20 ← 0x33333333, then sb 0x20 ← 0x44.
  - After the second store, a read of 0x20 returns 0x22111111.
  - After all four stores, a read of 0x20 returns 0x33333344, with `wbcount`=4 and `wbfull`=1.
  - Release `load_en`: the buffer empties in exactly 4 cycles and the RAM word holds 0x33333344.
- **Overflow:** hold `load_en` high and issue 5 consecutive stores with `WB_DEPTH`=4. The 5th is dropped, `wboverflow`=1 and stays set, and `wbcount`=4.
- **Full with simultaneous drain:** with the buffer full and `load_en` dropping to 0, a store on the same edge is accepted, `wbcount` stays 4 and `wboverflow` stays 0.
- **Reset mid-operation:** with 3 pending entries, pulse reset asynchronously between edges. `wbcount` goes to 0 immediately, the RAM keeps its pre-reset contents, and reads return the RAM words only.
